// File: rtl/b03_pkg.sv
// ---------------------------------------------------------------------------
// b03_pkg
// Shared definitions for the b03 resource-holder slice: FSM state encoding,
// requester count, and one-hot helpers used to qualify the arbiter grant.
// ---------------------------------------------------------------------------
package b03_pkg;

    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        RELEASE = 2'd2
    } state_e;

    // True when exactly one bit of vec is set.
    function automatic logic onehot_ok(input logic [NREQ-1:0] vec);
        int unsigned n;
        n = 0;
        for (int i = 0; i < NREQ; i++) begin
            if (vec[i]) n++;
        end
        return (n == 1);
    endfunction

    // Index of the lowest set bit; only meaningful when onehot_ok(vec).
    function automatic logic [1:0] onehot_idx(input logic [NREQ-1:0] vec);
        logic [1:0] idx;
        idx = 2'd0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (vec[i]) idx = 2'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/b03_sat_counter.sv
// ---------------------------------------------------------------------------
// b03_sat_counter
// Saturating up-counter: advances by one on each edge where inc is high and
// sticks at all-ones once reached.
// Ports:
//   clock  in   rising-edge clock
//   reset  in   asynchronous active-high clear
//   inc    in   increment request for this edge
//   count  out  CNT_W-bit current count
// ---------------------------------------------------------------------------
module b03_sat_counter #(
    parameter int CNT_W = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] count
);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != '1)) begin
            count_d = count_q + CNT_W'(1);
        end
    end

    // NOTE: sequential state is always assigned with <= so every flop samples
    // the pre-edge values of its neighbours.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) count_q <= '0;
        else       count_q <= count_d;
    end

    assign count = count_q;

endmodule

// File: rtl/b03_resource_holder.sv
// ---------------------------------------------------------------------------
// b03_resource_holder
// Models the shared resource downstream of the b03 round-robin arbiter. A
// one-hot grant sampled in IDLE makes the granted requester the owner for
// HOLD_CYCLES cycles (BUSY), followed by a one-cycle RELEASE that bumps that
// requester's saturating completed-hold counter. Sticky flags record illegal
// grant patterns.
// Ports:
//   clock          in   rising-edge clock
//   reset          in   asynchronous active-high clear of all state
//   grant[3:0]     in   one-hot grant from the arbiter, bit i = requester i+1
//   err_clear      in   synchronous clear of both error flags (set wins)
//   busy           out  resource held (state BUSY)
//   owner[1:0]     out  index of current/last holder
//   release_pulse  out  one-cycle pulse in RELEASE ('release' is a reserved word)
//   grant_cnt0..3  out  completed holds per requester, saturating
//   err_multi      out  sticky: multi-bit grant seen in IDLE
//   err_change     out  sticky: grant differed from captured owner in BUSY
// ---------------------------------------------------------------------------
module b03_resource_holder
    import b03_pkg::*;
#(
    parameter int HOLD_CYCLES = 4,
    parameter int CNT_W       = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [3:0]       grant,
    input  logic             err_clear,
    output logic             busy,
    output logic [1:0]       owner,
    output logic             release_pulse,
    output logic [CNT_W-1:0] grant_cnt0,
    output logic [CNT_W-1:0] grant_cnt1,
    output logic [CNT_W-1:0] grant_cnt2,
    output logic [CNT_W-1:0] grant_cnt3,
    output logic             err_multi,
    output logic             err_change
);

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES - 1);

    state_e     state_q, state_d;
    logic [7:0] hold_q, hold_d;
    logic [1:0] owner_q, owner_d;
    logic       busy_q, busy_d;
    logic       release_q, release_d;
    logic       err_multi_q, err_multi_d;
    logic       err_change_q, err_change_d;

    logic [NREQ-1:0] owner_onehot;
    assign owner_onehot = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;

    // NOTE: every always_comb output gets a default first so no path leaves
    // a signal unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d      = state_q;
        hold_d       = hold_q;
        owner_d      = owner_q;
        // Clear is applied first so that an error raised below on the same
        // edge overrides it.
        err_multi_d  = err_clear ? 1'b0 : err_multi_q;
        err_change_d = err_clear ? 1'b0 : err_change_q;

        unique case (state_q)
            IDLE: begin
                if (grant != '0) begin
                    if (onehot_ok(grant)) begin
                        owner_d = onehot_idx(grant);
                        hold_d  = HOLD_LOAD;
                        state_d = BUSY;
                    end else begin
                        err_multi_d = 1'b1;
                    end
                end
            end
            BUSY: begin
                if (grant != owner_onehot) err_change_d = 1'b1;
                if (hold_q == 8'd0) state_d = RELEASE;
                else                hold_d  = hold_q - 8'd1;
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Outputs are decoded from the next state so they come straight off
        // flops with no path from grant.
        busy_d    = (state_d == BUSY);
        release_d = (state_d == RELEASE);
    end

    // NOTE: all control state has an async reset; there is no memory array
    // here, so nothing is left to power up undefined.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            hold_q       <= 8'd0;
            owner_q      <= 2'd0;
            busy_q       <= 1'b0;
            release_q    <= 1'b0;
            err_multi_q  <= 1'b0;
            err_change_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_q       <= hold_d;
            owner_q      <= owner_d;
            busy_q       <= busy_d;
            release_q    <= release_d;
            err_multi_q  <= err_multi_d;
            err_change_q <= err_change_d;
        end
    end

    // Completed-hold counters: the owner's counter advances on the edge that
    // leaves RELEASE.
    logic [CNT_W-1:0] cnt [NREQ];

    for (genvar i = 0; i < NREQ; i++) begin : g_cnt
        b03_sat_counter #(.CNT_W(CNT_W)) u_cnt (
            .clock (clock),
            .reset (reset),
            .inc   (release_q && (owner_q == 2'(i))),
            .count (cnt[i])
        );
    end

    assign busy          = busy_q;
    assign owner         = owner_q;
    assign release_pulse = release_q;
    assign err_multi     = err_multi_q;
    assign err_change    = err_change_q;
    assign grant_cnt0    = cnt[0];
    assign grant_cnt1    = cnt[1];
    assign grant_cnt2    = cnt[2];
    assign grant_cnt3    = cnt[3];

endmodule
